// File: rtl/reg_bank_arbiter.sv
// Two-requester sequencer for the shared register bank: arbitrates READ/WRITE/XCHG
// commands round-robin and breaks each one into single bank read/write cycles.
module reg_bank_arbiter #(
  parameter int DW      = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][1:0]     req_op,
  input  logic [1:0][2:0]     req_sel_a,
  input  logic [1:0][2:0]     req_sel_b,
  input  logic [1:0]          req_hl_a,
  input  logic [1:0]          req_hl_b,
  input  logic [1:0]          req_size,
  input  logic [1:0][DW-1:0]  req_wdata,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [DW-1:0]       rsp_data,
  output logic [2:0]          bank_select_reg,
  output logic                bank_size,
  output logic                bank_select_hl,
  output logic                bank_select_dh,
  output logic                bank_read_write,
  output logic [DW-1:0]       bank_wdata,
  input  logic [DW-1:0]       bank_rdata,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, RD, WR, XRA, XRB, XWA, XWB, RSP} state_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [2:0]    sel_a;
    logic [2:0]    sel_b;
    logic          hl_a;
    logic          hl_b;
    logic          size;
    logic [DW-1:0] wdata;
  } cmd_t;

  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_XCHG = 2'b10;

  state_t        state, nxt;
  cmd_t          cmd;
  logic          owner, prio, gnt, accept;
  logic [DW-1:0] tmp_a, tmp_b, rd_val;

  // Both valid -> priority holder wins; otherwise the lone valid requester.
  assign gnt       = req_valid[1] & (~req_valid[0] | prio);
  assign accept    = reset && (state == IDLE) && (|req_valid);
  assign req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  // Byte reads come back in [7:0] and are zero-extended.
  assign rd_val = cmd.size ? bank_rdata : {{(DW-8){1'b0}}, bank_rdata[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) begin
        case (req_op[gnt])
          OP_RD:   nxt = RD;
          OP_WR:   nxt = WR;
          OP_XCHG: nxt = XRA;
          default: nxt = RSP;
        endcase
      end
      RD, WR:  nxt = RSP;
      XRA:     nxt = XRB;
      XRB:     nxt = XWA;
      XWA:     nxt = XWB;
      XWB:     nxt = RSP;
      RSP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd      <= '0;
      owner    <= 1'b0;
      prio     <= RR_INIT;
      tmp_a    <= '0;
      tmp_b    <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        owner       <= gnt;
        prio        <= ~gnt;
        cmd.op      <= req_op[gnt];
        cmd.sel_a   <= req_sel_a[gnt];
        cmd.sel_b   <= req_sel_b[gnt];
        cmd.hl_a    <= req_hl_a[gnt];
        cmd.hl_b    <= req_hl_b[gnt];
        cmd.size    <= req_size[gnt];
        cmd.wdata   <= req_size[gnt] ? req_wdata[gnt]
                                     : {{(DW-8){1'b0}}, req_wdata[gnt][7:0]};
        if (req_op[gnt] == 2'b11) rsp_data <= '0;
      end
      case (state)
        RD:      rsp_data <= rd_val;
        XRA:     tmp_a    <= rd_val;
        XRB:     tmp_b    <= rd_val;
        XWB:     rsp_data <= tmp_a;
        default: ;
      endcase
    end
  end

  always_comb begin
    bank_select_reg = '0;
    bank_size       = 1'b0;
    bank_select_hl  = 1'b0;
    bank_read_write = 1'b0;
    bank_wdata      = '0;
    case (state)
      RD, XRA, WR, XWA: begin
        bank_select_reg = cmd.sel_a;
        bank_size       = cmd.size;
        bank_select_hl  = ~cmd.size & cmd.hl_a;
      end
      XRB, XWB: begin
        bank_select_reg = cmd.sel_b;
        bank_size       = cmd.size;
        bank_select_hl  = ~cmd.size & cmd.hl_b;
      end
      default: ;
    endcase
    case (state)
      WR:  begin bank_read_write = 1'b1; bank_wdata = cmd.wdata; end
      XWA: begin bank_read_write = 1'b1; bank_wdata = tmp_b;     end
      XWB: begin bank_read_write = 1'b1; bank_wdata = tmp_a;     end
      default: ;
    endcase
  end

  assign bank_select_dh = 1'b0;
  assign busy           = (state != IDLE);
  assign rsp_valid      = (state == RSP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err        = (state == RSP) && (cmd.op == 2'b11);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural 8x16 register bank attached.
module tb_reg_bank_arbiter;
  localparam bit RR = 1'b0;
  localparam logic [2:0] AX = 3'd0, BX = 3'd1, CX = 3'd2, DX = 3'd3;

  logic             clk = 0, reset = 0;
  logic [1:0]       req_valid = '0, req_ready;
  logic [1:0][1:0]  req_op = '0;
  logic [1:0][2:0]  req_sel_a = '0, req_sel_b = '0;
  logic [1:0]       req_hl_a = '0, req_hl_b = '0, req_size = '0;
  logic [1:0][15:0] req_wdata = '0;
  logic [1:0]       rsp_valid;
  logic             rsp_err;
  logic [15:0]      rsp_data;
  logic [2:0]       bank_select_reg;
  logic             bank_size, bank_select_hl, bank_select_dh, bank_read_write;
  logic [15:0]      bank_wdata, bank_rdata;
  logic             busy;

  int checks = 0, errors = 0;
  logic [15:0] regs [8];

  reg_bank_arbiter #(.DW(16), .RR_INIT(RR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sel_a(req_sel_a), .req_sel_b(req_sel_b),
    .req_hl_a(req_hl_a), .req_hl_b(req_hl_b), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .bank_select_reg(bank_select_reg), .bank_size(bank_size), .bank_select_hl(bank_select_hl),
    .bank_select_dh(bank_select_dh), .bank_read_write(bank_read_write),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .busy(busy));

  always #5 clk = ~clk;

  // Register bank stand-in: combinational read, write on the edge ending a write cycle.
  always_comb begin
    if (bank_size)           bank_rdata = regs[bank_select_reg];
    else if (bank_select_hl) bank_rdata = {8'h00, regs[bank_select_reg][15:8]};
    else                     bank_rdata = {8'h00, regs[bank_select_reg][7:0]};
  end

  always @(posedge clk) begin
    if (bank_read_write) begin
      if (bank_size)           regs[bank_select_reg]       <= bank_wdata;
      else if (bank_select_hl) regs[bank_select_reg][15:8] <= bank_wdata[7:0];
      else                     regs[bank_select_reg][7:0]  <= bank_wdata[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command; lat = edges after acceptance at which the response is sampled.
  task automatic do_cmd(input int r, input logic [1:0] op, input logic [2:0] sa, input logic [2:0] sb,
                        input logic ha, input logic hb, input logic sz, input logic [15:0] wd,
                        output int lat, output logic [15:0] data, output logic err,
                        output logic rw_seen);
    int n = 0;
    lat = 0; data = '0; err = 1'b0; rw_seen = 1'b0;
    @(negedge clk);
    req_op[r] = op; req_sel_a[r] = sa; req_sel_b[r] = sb;
    req_hl_a[r] = ha; req_hl_b[r] = hb; req_size[r] = sz; req_wdata[r] = wd;
    req_valid[r] = 1'b1;
    #1;
    while (!req_ready[r] && n < 20) begin @(negedge clk); #1; n++; end
    if (!req_ready[r]) chk("ready_timeout", 32'(req_ready[r]), 32'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    req_wdata[r] = 16'hDEAD; req_sel_a[r] = ~sa; req_sel_b[r] = ~sb; req_size[r] = ~sz;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rw_seen |= bank_read_write;
      if (rsp_valid[r]) begin lat = k; data = rsp_data; err = rsp_err; break; end
    end
  endtask

  int lat, n;
  logic [15:0] d;
  logic e, rw;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    #12;
    chk("rst_ready",  32'(req_ready), 32'd0);
    chk("rst_rspv",   32'(rsp_valid), 32'd0);
    chk("rst_rspd",   32'(rsp_data), 32'd0);
    chk("rst_bank",   32'({bank_select_reg, bank_size, bank_select_hl, bank_select_dh,
                           bank_read_write, bank_wdata}), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Round-robin with both requesters permanently valid.
    @(negedge clk);
    req_op = '0; req_sel_a = '0; req_size = 2'b11; req_valid = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
      chk("rr_grant", 32'(req_ready), (RR ^ g[0]) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk); req_valid = '0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("rr_drain", 32'(busy), 32'd0);

    // Word write then read through requester 0.
    do_cmd(0, 2'b01, AX, AX, 0, 0, 1, 16'h1234, lat, d, e, rw);
    chk("wr_lat", 32'(lat), 32'd2);
    do_cmd(0, 2'b00, AX, AX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_data", 32'(d), 32'h1234);
    chk("rd_err", 32'(e), 32'd0);
    repeat (3) @(negedge clk);
    chk("rsp_hold", 32'(rsp_data), 32'h1234);

    // Byte write into BH via requester 1; BL must survive.
    do_cmd(1, 2'b01, BX, BX, 0, 0, 1, 16'h3377, lat, d, e, rw);
    do_cmd(1, 2'b01, BX, BX, 1, 0, 0, 16'hFFA5, lat, d, e, rw);
    do_cmd(1, 2'b00, BX, BX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("byte_word", 32'(d), 32'hA577);
    do_cmd(1, 2'b00, BX, BX, 0, 0, 0, 16'h0, lat, d, e, rw);
    chk("byte_lo", 32'(d), 32'h0077);
    do_cmd(0, 2'b00, BX, BX, 1, 0, 0, 16'h0, lat, d, e, rw);
    chk("byte_hi", 32'(d), 32'h00A5);

    // Exchange AX/CX.
    do_cmd(0, 2'b01, AX, AX, 0, 0, 1, 16'h1111, lat, d, e, rw);
    do_cmd(0, 2'b01, CX, CX, 0, 0, 1, 16'h2222, lat, d, e, rw);
    do_cmd(1, 2'b10, AX, CX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("xchg_lat", 32'(lat), 32'd5);
    chk("xchg_data", 32'(d), 32'h1111);
    do_cmd(0, 2'b00, AX, AX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("xchg_ax", 32'(d), 32'h2222);
    do_cmd(0, 2'b00, CX, CX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("xchg_cx", 32'(d), 32'h1111);

    // Self-exchange leaves the register unchanged.
    do_cmd(0, 2'b01, DX, DX, 0, 0, 1, 16'h5A5A, lat, d, e, rw);
    do_cmd(0, 2'b10, DX, DX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("xself_data", 32'(d), 32'h5A5A);
    do_cmd(0, 2'b00, DX, DX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("xself_dx", 32'(d), 32'h5A5A);

    // Illegal op.
    do_cmd(1, 2'b11, AX, AX, 0, 0, 1, 16'hBEEF, lat, d, e, rw);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_err", 32'(e), 32'd1);
    chk("ill_data", 32'(d), 32'd0);
    chk("ill_rw", 32'(rw), 32'd0);

    // Reset during the first write of an exchange: neither register may change.
    do_cmd(0, 2'b01, BX, BX, 0, 0, 1, 16'h00AA, lat, d, e, rw);
    do_cmd(0, 2'b01, DX, DX, 0, 0, 1, 16'h5555, lat, d, e, rw);
    @(negedge clk);
    req_op[0] = 2'b10; req_sel_a[0] = BX; req_sel_b[0] = DX; req_size[0] = 1'b1;
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1; req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_xwa_rw", 32'(bank_read_write), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_bank", 32'({bank_select_reg, bank_size, bank_select_hl, bank_read_write,
                         bank_wdata}), 32'd0);
    chk("mid_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
    @(negedge clk); reset = 1'b1;
    do_cmd(0, 2'b00, BX, BX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("mid_bx", 32'(d), 32'h00AA);
    do_cmd(0, 2'b00, DX, DX, 0, 0, 1, 16'h0, lat, d, e, rw);
    chk("mid_dx", 32'(d), 32'h5555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
